// File: rtl/axis_spi_slave_if.sv
// Word-stream handshake bundle for axis_spi_slave: TX words in, RX words out.
interface axis_spi_slave_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] axis_wdata;
    logic                  axis_wvalid;
    logic                  axis_wready;
    logic [DATA_WIDTH-1:0] axis_rdata;
    logic                  axis_rvalid;
    logic                  axis_rready;

    modport master (
        output axis_wdata, axis_wvalid, axis_rready,
        input  axis_wready, axis_rdata, axis_rvalid
    );

    modport slave (
        input  axis_wdata, axis_wvalid, axis_rready,
        output axis_wready, axis_rdata, axis_rvalid
    );
endinterface

// File: rtl/axis_spi_slave.sv
// Oversampled SPI responder: MOSI words to an RX stream, TX stream words back on MISO.
// Optional end-of-frame interrupt enabled by defining SPI_SLAVE_IRQ_EN.
module axis_spi_slave #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter bit                    SCK_LO      = 1'b1,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = '0
) (
    input  logic               axis_clk,
    input  logic               axis_resetn,
    axis_spi_slave_if.slave    axis,
    input  logic               spi_sclk,
    input  logic               spi_sen,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               spi_miso_oe,
    output logic               rx_overflow,
    output logic               tx_underrun,
    output logic               frame_error,
    output logic               spi_interrupt_valid,
    input  logic               spi_interrupt_ready
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;

    // SEN resets to "selected" so a reset inside a frame waits for the frame to end.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sen_sync_q, mosi_sync_q;
    logic                   sclk_hist_q, sen_hist_q;

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            sclk_sync_q <= '0;
            sen_sync_q  <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            sen_hist_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], spi_sen};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            sen_hist_q  <= sen_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, sen_s, mosi_s;
    logic sclk_rise, sclk_fall, sen_rise, sen_fall;
    logic sample_edge, launch_edge;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign sen_s       = sen_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_hist_q;
    assign sclk_fall   = ~sclk_s & sclk_hist_q;
    assign sen_rise    = sen_s & ~sen_hist_q;
    assign sen_fall    = ~sen_s & sen_hist_q;
    assign sample_edge = SCK_LO ? sclk_rise : sclk_fall;
    assign launch_edge = SCK_LO ? sclk_fall : sclk_rise;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
    logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  sampled_q, sampled_d;
    logic                  done_q, done_d;
    logic                  udr_pend_q, udr_pend_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  miso_q, miso_d;
    logic                  oe_q, oe_d;
    logic                  ovf_q, ovf_d;
    logic                  udr_q, udr_d;
    logic                  ferr_q, ferr_d;
    logic                  tx_load, tx_take, hold_load, rx_accept;

    always_comb begin
        state_d    = state_q;
        shift_rx_d = shift_rx_q;
        shift_tx_d = shift_tx_q;
        bit_cnt_d  = bit_cnt_q;
        sampled_d  = sampled_q;
        udr_pend_d = udr_pend_q;
        done_d     = 1'b0;
        udr_d      = 1'b0;
        ferr_d     = 1'b0;
        tx_load    = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (sen_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (sen_fall) begin
                    state_d    = ST_SHIFT;
                    tx_load    = 1'b1;
                    bit_cnt_d  = '0;
                    sampled_d  = 1'b0;
                    udr_pend_d = 1'b0;
                    udr_d      = ~hold_full_q;
                end
            end
            ST_SHIFT: begin
                if (sen_rise) begin
                    state_d    = ST_IDLE;
                    ferr_d     = (bit_cnt_q != '0);
                    sampled_d  = 1'b0;
                    udr_pend_d = 1'b0;
                end else if (sample_edge) begin
                    shift_rx_d = {shift_rx_q[DATA_WIDTH-2:0], mosi_s};
                    sampled_d  = 1'b1;
                    // Underrun of a back-to-back word is flagged only once that word really starts,
                    // so the trailing launch edge of the last word in a frame never reports one.
                    udr_d      = udr_pend_q;
                    udr_pend_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (launch_edge && sampled_q) begin
                    if (bit_cnt_q == '0) begin
                        tx_load    = 1'b1;
                        sampled_d  = 1'b0;
                        udr_pend_d = ~hold_full_q;
                    end else begin
                        shift_tx_d = {shift_tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        if (tx_load) shift_tx_d = hold_full_q ? hold_q : TX_DEFAULT;
    end

    assign tx_take   = tx_load & hold_full_q;
    assign hold_load = axis.axis_wvalid & ~hold_full_q;
    assign rx_accept = rvalid_q & axis.axis_rready;

    always_comb begin
        hold_full_d = hold_load | (hold_full_q & ~tx_take);
        hold_d      = hold_load ? axis.axis_wdata : hold_q;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q & ~rx_accept;
        ovf_d       = 1'b0;
        if (done_q) begin
            if (!rvalid_q || rx_accept) begin
                rdata_d  = shift_rx_q;
                rvalid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        miso_d = (state_q == ST_SHIFT) ? shift_tx_q[DATA_WIDTH-1] : 1'b0;
        oe_d   = (state_q == ST_SHIFT);
    end

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q     <= ST_WAIT_IDLE;
            shift_rx_q  <= '0;
            shift_tx_q  <= '0;
            bit_cnt_q   <= '0;
            sampled_q   <= 1'b0;
            done_q      <= 1'b0;
            udr_pend_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            ovf_q       <= 1'b0;
            udr_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_rx_q  <= shift_rx_d;
            shift_tx_q  <= shift_tx_d;
            bit_cnt_q   <= bit_cnt_d;
            sampled_q   <= sampled_d;
            done_q      <= done_d;
            udr_pend_q  <= udr_pend_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            ovf_q       <= ovf_d;
            udr_q       <= udr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign axis.axis_wready = ~hold_full_q;
    assign axis.axis_rdata  = rdata_q;
    assign axis.axis_rvalid = rvalid_q;
    assign spi_miso         = miso_q;
    assign spi_miso_oe      = oe_q;
    assign rx_overflow      = ovf_q;
    assign tx_underrun      = udr_q;
    assign frame_error      = ferr_q;

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_q;

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            irq_q <= 1'b0;
        end else if (state_q == ST_SHIFT && sen_rise) begin
            irq_q <= 1'b1;
        end else if (irq_q && spi_interrupt_ready) begin
            irq_q <= 1'b0;
        end
    end

    assign spi_interrupt_valid = irq_q;
`else
    logic unused_irq_ready;

    assign unused_irq_ready    = spi_interrupt_ready;
    assign spi_interrupt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_axis_spi_slave.sv
// Directed bench for axis_spi_slave in SPI mode 0, SCLK = axis_clk/8.
module tb_axis_spi_slave;

    localparam logic [31:0] TXD = 32'h0BAD_F00D;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk, sen, mosi;
    logic miso, miso_oe, ovf, udr, ferr, irq_valid, irq_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_cnt  = 0;
    int udr_cnt  = 0;
    int ferr_cnt = 0;

    axis_spi_slave_if #(.DATA_WIDTH(32)) axis_bus ();

    axis_spi_slave #(
        .DATA_WIDTH (32),
        .SCK_LO     (1'b1),
        .SYNC_STAGES(2),
        .TX_DEFAULT (TXD)
    ) dut (
        .axis_clk           (clk),
        .axis_resetn        (rst_n),
        .axis               (axis_bus),
        .spi_sclk           (sclk),
        .spi_sen            (sen),
        .spi_mosi           (mosi),
        .spi_miso           (miso),
        .spi_miso_oe        (miso_oe),
        .rx_overflow        (ovf),
        .tx_underrun        (udr),
        .frame_error        (ferr),
        .spi_interrupt_valid(irq_valid),
        .spi_interrupt_ready(irq_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ovf)  ovf_cnt++;
        if (udr)  udr_cnt++;
        if (ferr) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives change 3 ns after a rising clock edge, away from the sampling point.
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic push(input logic [31:0] d);
        axis_bus.axis_wdata  = d;
        axis_bus.axis_wvalid = 1'b1;
        clks(1);
        axis_bus.axis_wvalid = 1'b0;
    endtask

    task automatic pop();
        axis_bus.axis_rready = 1'b1;
        clks(1);
        axis_bus.axis_rready = 1'b0;
    endtask

    task automatic sen_assert();
        sen = 1'b0;
        clks(4);
    endtask

    task automatic sen_release();
        sen = 1'b1;
        clks(6);
    endtask

    task automatic spi_bits(input logic [31:0] w, input int nbits, output logic [31:0] r);
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[31-i];
            clks(4);
            r[31-i] = miso;
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        clks(4);
    endtask

    logic [31:0] r1, r2;
    int ovf0, udr0, ferr0;

    initial begin
        rst_n = 1'b0;
        sclk = 1'b0; sen = 1'b1; mosi = 1'b0; irq_ready = 1'b0;
        axis_bus.axis_wdata = '0; axis_bus.axis_wvalid = 1'b0; axis_bus.axis_rready = 1'b0;
        clks(3);
        check("rst_wready", {31'd0, axis_bus.axis_wready}, 32'd1);
        check("rst_rvalid", {31'd0, axis_bus.axis_rvalid}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_irq", {31'd0, irq_valid}, 32'd0);
        rst_n = 1'b1;
        clks(6);

        // Preloaded TX word returned while a word is received
        udr0 = udr_cnt;
        push(32'hA5A5_0F0F);
        check("t1_wready_full", {31'd0, axis_bus.axis_wready}, 32'd0);
        sen_assert();
        check("t1_oe", {31'd0, miso_oe}, 32'd1);
        spi_bits(32'h1234_5678, 32, r1);
        sen_release();
        check("t1_miso_word", r1, 32'hA5A5_0F0F);
        check("t1_rdata", axis_bus.axis_rdata, 32'h1234_5678);
        check("t1_rvalid", {31'd0, axis_bus.axis_rvalid}, 32'd1);
        check("t1_wready_empty", {31'd0, axis_bus.axis_wready}, 32'd1);
        check("t1_oe_off", {31'd0, miso_oe}, 32'd0);
        check("t1_udr", udr_cnt - udr0, 32'd0);
`ifdef SPI_SLAVE_IRQ_EN
        check("t1_irq_set", {31'd0, irq_valid}, 32'd1);
        clks(3);
        check("t1_irq_held", {31'd0, irq_valid}, 32'd1);
        irq_ready = 1'b1;
        clks(1);
        irq_ready = 1'b0;
        check("t1_irq_ack", {31'd0, irq_valid}, 32'd0);
`else
        check("t1_irq_off", {31'd0, irq_valid}, 32'd0);
`endif
        pop();
        check("t1_pop", {31'd0, axis_bus.axis_rvalid}, 32'd0);

        // Underrun: nothing queued
        udr0 = udr_cnt;
        sen_assert();
        spi_bits(32'h0000_FFFF, 32, r1);
        sen_release();
        check("t2_miso_default", r1, TXD);
        check("t2_udr", udr_cnt - udr0, 32'd1);
        check("t2_wready", {31'd0, axis_bus.axis_wready}, 32'd1);
        check("t2_rdata", axis_bus.axis_rdata, 32'h0000_FFFF);
        pop();

        // Two words in one frame with the RX side stalled
        ovf0 = ovf_cnt; udr0 = udr_cnt; ferr0 = ferr_cnt;
        push(32'h1111_2222);
        sen_assert();
        spi_bits(32'hCAFE_F00D, 32, r1);
        check("t3_first_rvalid", {31'd0, axis_bus.axis_rvalid}, 32'd1);
        check("t3_first_rdata", axis_bus.axis_rdata, 32'hCAFE_F00D);
        spi_bits(32'h0123_4567, 32, r2);
        sen_release();
        check("t3_miso_w1", r1, 32'h1111_2222);
        check("t3_miso_w2", r2, TXD);
        check("t3_rdata_kept", axis_bus.axis_rdata, 32'hCAFE_F00D);
        check("t3_ovf", ovf_cnt - ovf0, 32'd1);
        check("t3_udr", udr_cnt - udr0, 32'd1);
        check("t3_ferr", ferr_cnt - ferr0, 32'd0);
        pop();
        check("t3_pop", {31'd0, axis_bus.axis_rvalid}, 32'd0);

        // Frame aborted after 10 bits, then a clean frame
        ferr0 = ferr_cnt;
        sen_assert();
        spi_bits(32'hFFC0_0000, 10, r1);
        sen_release();
        check("t4_ferr", ferr_cnt - ferr0, 32'd1);
        check("t4_no_rvalid", {31'd0, axis_bus.axis_rvalid}, 32'd0);
        push(32'h5A5A_5A5A);
        sen_assert();
        spi_bits(32'hDEAD_BEEF, 32, r1);
        sen_release();
        check("t4_rdata", axis_bus.axis_rdata, 32'hDEAD_BEEF);
        check("t4_rvalid", {31'd0, axis_bus.axis_rvalid}, 32'd1);
        check("t4_miso_word", r1, 32'h5A5A_5A5A);
        check("t4_ferr_once", ferr_cnt - ferr0, 32'd1);
        pop();

        // Reset in the middle of a frame
        ferr0 = ferr_cnt;
        push(32'h7777_8888);
        sen_assert();
        spi_bits(32'hFFFF_FFFF, 12, r1);
        rst_n = 1'b0;
        clks(2);
        check("t5_rst_oe", {31'd0, miso_oe}, 32'd0);
        check("t5_rst_wready", {31'd0, axis_bus.axis_wready}, 32'd1);
        check("t5_rst_irq", {31'd0, irq_valid}, 32'd0);
        rst_n = 1'b1;
        clks(2);
        spi_bits(32'hAAAA_AAAA, 20, r1);
        check("t5_ignored_rvalid", {31'd0, axis_bus.axis_rvalid}, 32'd0);
        check("t5_ignored_oe", {31'd0, miso_oe}, 32'd0);
        check("t5_ignored_miso", {31'd0, miso}, 32'd0);
        sen_release();
        check("t5_no_ferr", ferr_cnt - ferr0, 32'd0);
        sen_assert();
        spi_bits(32'h0F1E_2D3C, 32, r1);
        sen_release();
        check("t5_rdata", axis_bus.axis_rdata, 32'h0F1E_2D3C);
        check("t5_rvalid", {31'd0, axis_bus.axis_rvalid}, 32'd1);
        check("t5_miso_default", r1, TXD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
